// File: rtl/fnd_scan_receiver.sv
// Readback receiver for the multiplexed 4-digit FND display.
// Rebuilds the displayed decimal value from the active-low segment/common lines.
module fnd_scan_receiver #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  fndFont,
  input  logic [3:0]  fndCom,
  input  logic        clr_err,
  output logic [13:0] digit,
  output logic        digit_valid,
  output logic        err_font,
  output logic        err_range,
  output logic        err_timeout
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_HOLD,
    S_CALC
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [7:0]       font_meta_reg;
  logic [7:0]       font_sync_reg;
  logic [3:0]       com_meta_reg;
  logic [3:0]       com_sync_reg;
  logic [11:0]      pair;
  logic [11:0]      pair_prev_reg;
  logic             pair_changed;
  logic [CNT_W-1:0] cnt_reg;
  logic [TO_W-1:0]  to_reg;
  logic             timeout_hit;

  logic             slot_valid;
  logic [1:0]       slot_idx;
  logic [3:0]       slot_onehot;
  logic             font_valid;
  logic [3:0]       font_val;

  logic             capture;
  logic [3:0]       mask_reg;
  logic [3:0][3:0]  slots;
  logic [3:0]       slot_hex;
  logic             any_hex;
  logic [13:0]      frame_sum;

  logic [13:0]      digit_reg;
  logic             digit_valid_reg;
  logic             err_font_reg;
  logic             err_range_reg;
  logic             err_timeout_reg;

  // Two-flop synchronizer; idle (all lines high) is the reset pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      font_meta_reg <= 8'hFF;
      font_sync_reg <= 8'hFF;
      com_meta_reg  <= 4'hF;
      com_sync_reg  <= 4'hF;
      pair_prev_reg <= 12'hFFF;
    end else begin
      font_meta_reg <= fndFont;
      font_sync_reg <= font_meta_reg;
      com_meta_reg  <= fndCom;
      com_sync_reg  <= com_meta_reg;
      pair_prev_reg <= pair;
    end
  end

  assign pair         = {com_sync_reg, font_sync_reg};
  assign pair_changed = (pair != pair_prev_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (pair_changed) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    slot_valid = 1'b1;
    slot_idx   = 2'd0;
    case (com_sync_reg)
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: slot_valid = 1'b0;
    endcase
  end

  assign slot_onehot = 4'b0001 << slot_idx;

  always_comb begin
    font_valid = 1'b1;
    font_val   = 4'd0;
    case (font_sync_reg)
      8'hC0: font_val = 4'h0;
      8'hF9: font_val = 4'h1;
      8'hA4: font_val = 4'h2;
      8'hB0: font_val = 4'h3;
      8'h99: font_val = 4'h4;
      8'h92: font_val = 4'h5;
      8'h82: font_val = 4'h6;
      8'hF8: font_val = 4'h7;
      8'h80: font_val = 4'h8;
      8'h90: font_val = 4'h9;
      8'h88: font_val = 4'hA;
      8'h83: font_val = 4'hB;
      8'hC6: font_val = 4'hC;
      8'hA1: font_val = 4'hD;
      8'h86: font_val = 4'hE;
      8'h8E: font_val = 4'hF;
      default: font_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture only while the pair is still the one the counter has been timing.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      S_WAIT: begin
        if ((cnt_reg == CNT_MAX) && !pair_changed && slot_valid) begin
          capture = 1'b1;
          if (font_valid && ((mask_reg | slot_onehot) == 4'hF)) begin
            state_next = S_CALC;
          end else begin
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (pair_changed) begin
          state_next = S_WAIT;
        end
      end
      S_CALC: begin
        // A dwell edge landing in this cycle must not be lost behind S_HOLD.
        state_next = pair_changed ? S_WAIT : S_HOLD;
      end
      default: state_next = S_WAIT;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [3:0] d_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          d_reg <= 4'd0;
        end else if (capture && font_valid && (slot_idx == 2'(gi))) begin
          d_reg <= font_val;
        end
      end
      assign slots[gi]    = d_reg;
      assign slot_hex[gi] = (d_reg > 4'd9);
    end
  endgenerate

  assign any_hex   = |slot_hex;
  assign frame_sum = 14'(slots[3]) * 14'd1000 + 14'(slots[2]) * 14'd100
                   + 14'(slots[1]) * 14'd10 + 14'(slots[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg <= 4'd0;
    end else if (timeout_hit) begin
      mask_reg <= 4'd0;
    end else if (capture) begin
      mask_reg <= font_valid ? (mask_reg | slot_onehot) : 4'd0;
    end else if (state_reg == S_CALC) begin
      mask_reg <= 4'd0;
    end
  end

  assign timeout_hit = (to_reg == TO_MAX) && (state_reg != S_CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_reg <= '0;
    end else if ((state_reg == S_CALC) || timeout_hit) begin
      to_reg <= '0;
    end else begin
      to_reg <= to_reg + TO_W'(1);
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_reg       <= 14'd0;
      digit_valid_reg <= 1'b0;
      err_font_reg    <= 1'b0;
      err_range_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      digit_valid_reg <= (state_reg == S_CALC) && !any_hex;
      if ((state_reg == S_CALC) && !any_hex) begin
        digit_reg <= frame_sum;
      end
      err_font_reg    <= (capture && !font_valid) || (err_font_reg && !clr_err);
      err_range_reg   <= ((state_reg == S_CALC) && any_hex) || (err_range_reg && !clr_err);
      err_timeout_reg <= timeout_hit || (err_timeout_reg && !clr_err);
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = digit_valid_reg;
  assign err_font    = err_font_reg;
  assign err_range   = err_range_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_fnd_scan_receiver.sv
// Scoreboard bench: a dwell-level model predicts frames and flags for the FND receiver.
`timescale 1ns/1ps
module tb_fnd_scan_receiver;

  localparam int STABLE = 16;
  localparam int LONG   = 50;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr_err;
  logic [7:0]  fnd_font;
  logic [3:0]  fnd_com;
  logic [13:0] digit;
  logic        digit_valid, err_font, err_range, err_timeout;

  logic        reset_to, clr_err_to;
  logic [7:0]  fnd_font_to;
  logic [3:0]  fnd_com_to;
  logic [13:0] digit_to;
  logic        digit_valid_to, err_font_to, err_range_to, err_timeout_to;

  fnd_scan_receiver #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(50_000)) dut (
    .clk(clk), .reset(reset), .fndFont(fnd_font), .fndCom(fnd_com), .clr_err(clr_err),
    .digit(digit), .digit_valid(digit_valid), .err_font(err_font),
    .err_range(err_range), .err_timeout(err_timeout)
  );

  fnd_scan_receiver #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(1000)) dut_to (
    .clk(clk), .reset(reset_to), .fndFont(fnd_font_to), .fndCom(fnd_com_to), .clr_err(clr_err_to),
    .digit(digit_to), .digit_valid(digit_valid_to), .err_font(err_font_to),
    .err_range(err_range_to), .err_timeout(err_timeout_to)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d, required %0d", tag, actual, expected);
    end
  endtask

  // Reference model state
  int          m_d[4];
  logic [3:0]  m_mask;
  logic        exp_font, exp_range;
  int          last_digit;
  logic [11:0] last_pair;
  int          exp_q[$];

  function automatic int font_value(input logic [7:0] f);
    case (f)
      8'hC0: return 0;  8'hF9: return 1;  8'hA4: return 2;  8'hB0: return 3;
      8'h99: return 4;  8'h92: return 5;  8'h82: return 6;  8'hF8: return 7;
      8'h80: return 8;  8'h90: return 9;  8'h88: return 10; 8'h83: return 11;
      8'hC6: return 12; 8'hA1: return 13; 8'h86: return 14; 8'h8E: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mask     = 4'd0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
    exp_font   = 1'b0;
    exp_range  = 1'b0;
    last_digit = 0;
    last_pair  = 12'hFFF;
  endtask

  // Drive one dwell on the main DUT starting at a negedge; update the model.
  task automatic dwell(input logic [3:0] c, input logic [7:0] f, input int n);
    int s, v;
    fnd_com  = c;
    fnd_font = f;
    s = slot_of(c);
    v = font_value(f);
    if (n >= STABLE + 4 && s >= 0 && {c, f} != last_pair) begin
      if (v < 0) begin
        exp_font = 1'b1;
        m_mask   = 4'd0;
      end else begin
        m_d[s]    = v;
        m_mask[s] = 1'b1;
        if (m_mask == 4'hF) begin
          m_mask = 4'd0;
          if (m_d[0] > 9 || m_d[1] > 9 || m_d[2] > 9 || m_d[3] > 9) begin
            exp_range = 1'b1;
          end else begin
            last_digit = m_d[3] * 1000 + m_d[2] * 100 + m_d[1] * 10 + m_d[0];
            exp_q.push_back(last_digit);
          end
        end
      end
    end
    last_pair = {c, f};
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_check(input string tag);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_digit"}, digit, last_digit);
    check_val({tag, "_err_font"}, err_font, exp_font);
    check_val({tag, "_err_range"}, err_range, exp_range);
    check_val({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Output monitors
  int   pulses = 0;
  int   pulses_to = 0;
  int   mon_e;
  logic prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (digit_valid === 1'b1) begin
        pulses++;
        check_val("valid_width", prev_valid, 0);
        check_val("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          $display("frame %0d: digit=%0d expected=%0d", pulses, digit, mon_e);
          check_val("frame_digit", digit, mon_e);
        end
      end
      prev_valid = digit_valid;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (digit_valid_to === 1'b1) pulses_to++;
    end
  end

  initial begin
    reset = 1'b0; clr_err = 1'b0; fnd_font = 8'hFF; fnd_com = 4'hF;
    reset_to = 1'b0; clr_err_to = 1'b0; fnd_font_to = 8'hFF; fnd_com_to = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_digit", digit, 0);
    check_val("rst_valid", digit_valid, 0);
    check_val("rst_err_font", err_font, 0);
    check_val("rst_err_range", err_range, 0);
    check_val("rst_err_timeout", err_timeout, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Normal frame 1234
    dwell(4'b1110, 8'h99, LONG);
    dwell(4'b1101, 8'hB0, LONG);
    dwell(4'b1011, 8'hA4, LONG);
    dwell(4'b0111, 8'hF9, LONG);
    frame_check("normal");
    dwell(4'b1111, 8'hFF, 30);

    // Glitch rejection, 5678 with short foreign pairs on slot 0
    dwell(4'b0111, 8'h92, LONG);
    dwell(4'b1011, 8'h82, LONG);
    dwell(4'b1110, 8'hC0, 10);
    dwell(4'b1110, 8'h80, 10);
    dwell(4'b1101, 8'hF8, LONG);
    dwell(4'b1110, 8'h80, LONG);
    frame_check("glitch");

    // Bad font mid-frame
    dwell(4'b0111, 8'hC0, LONG);
    dwell(4'b1011, 8'hC0, LONG);
    dwell(4'b1101, 8'hFF, LONG);
    dwell(4'b1110, 8'h99, LONG);
    frame_check("badfont");
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_font = 1'b0;
    check_val("badfont_cleared", err_font, 0);

    // Good frame 9876, then a frame with hex digit A in slot 2
    dwell(4'b1110, 8'h82, LONG);
    dwell(4'b1101, 8'hF8, LONG);
    dwell(4'b1011, 8'h80, LONG);
    dwell(4'b0111, 8'h90, LONG);
    frame_check("good9876");
    dwell(4'b1110, 8'hF9, LONG);
    dwell(4'b1101, 8'hA4, LONG);
    dwell(4'b1011, 8'h88, LONG);
    dwell(4'b0111, 8'hB0, LONG);
    frame_check("hex");
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_range = 1'b0;
    check_val("hex_cleared", err_range, 0);

    // Reset after three captures; slot 0 first afterwards exposes stale mask
    dwell(4'b0111, 8'h90, LONG);
    dwell(4'b1011, 8'h90, LONG);
    dwell(4'b1101, 8'h90, LONG);
    reset = 1'b0; fnd_com = 4'hF; fnd_font = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("midrst_digit", digit, 0);
    check_val("midrst_valid", digit_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    dwell(4'b1110, 8'hA4, LONG);
    dwell(4'b1101, 8'h99, LONG);
    dwell(4'b1011, 8'hC0, LONG);
    dwell(4'b0111, 8'hC0, LONG);
    frame_check("after_reset");
    check_val("after_reset_42", digit, 42);

    // Timeout on the second instance: slots 0-2 only, then slot 3 after the timeout
    reset_to = 1'b1;
    for (int cyc = 1; cyc <= 1020; cyc++) begin
      @(negedge clk);
      if (cyc < 840) begin
        case ((cyc / 40) % 3)
          0:       begin fnd_com_to = 4'b1110; fnd_font_to = 8'h99; end
          1:       begin fnd_com_to = 4'b1101; fnd_font_to = 8'hB0; end
          default: begin fnd_com_to = 4'b1011; fnd_font_to = 8'hA4; end
        endcase
      end else begin
        fnd_com_to = 4'hF; fnd_font_to = 8'hFF;
      end
      if (cyc == 995)  check_val("timeout_early", err_timeout_to, 0);
      if (cyc == 1005) check_val("timeout_set", err_timeout_to, 1);
    end
    fnd_com_to = 4'b0111; fnd_font_to = 8'hF9;
    repeat (60) @(negedge clk);
    check_val("timeout_mask_cleared", pulses_to, 0);
    check_val("timeout_err_font", err_font_to, 0);
    clr_err_to = 1'b1;
    @(negedge clk);
    clr_err_to = 1'b0;
    check_val("timeout_cleared", err_timeout_to, 0);

    check_val("total_pulses", pulses, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
